// File: rtl/pwm_clock_source_dt_if.sv
// Control/status bundle between the PWM control logic
// and the switching-clock source.
interface pwm_clock_source_dt_if #(
  parameter int WIDTH = 7,
  parameter int DT_W  = 4
);
  logic             start;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] duty;
  logic [DT_W-1:0]  dead_time;
  logic             load;
  logic             Fsw;
  logic             Fsw_n;
  logic [WIDTH-1:0] cnt;
  logic             period_end;

  modport master (
    output start, period, duty, dead_time, load,
    input  Fsw, Fsw_n, cnt, period_end
  );

  modport slave (
    input  start, period, duty, dead_time, load,
    output Fsw, Fsw_n, cnt, period_end
  );
endinterface

// File: rtl/pwm_clock_source_dt.sv
// Switching-clock source: period counter, shadowed
// period/duty/dead-time, complementary dead-time outputs.
module pwm_clock_source_dt #(
  parameter int WIDTH      = 7,
  parameter int DT_W       = 4,
  parameter int DEF_PERIOD = 100,
  parameter int DEF_DUTY   = 20,
  parameter int DEF_DT     = 0
) (
  input logic                 clk,
  input logic                 reset,
  pwm_clock_source_dt_if.slave bus
);
  localparam logic [WIDTH-1:0] P0 = WIDTH'(DEF_PERIOD);
  localparam logic [WIDTH-1:0] D0 = WIDTH'(DEF_DUTY);
  localparam logic [DT_W-1:0]  T0 = DT_W'(DEF_DT);

  logic [WIDTH-1:0] period_a;
  logic [WIDTH-1:0] duty_a;
  logic [DT_W-1:0]  dt_a;
  logic [WIDTH-1:0] period_s;
  logic [WIDTH-1:0] duty_s;
  logic [DT_W-1:0]  dt_s;
  logic             pending;
  logic [DT_W-1:0]  dt_cnt;
  logic             raw;
  logic             raw_q;
  logic             wrap;
  logic             wrap_ev;

  // ">=" forces a wrap even if the period drops below cnt
  assign wrap    = bus.cnt >= period_a;
  assign wrap_ev = bus.start & wrap;
  assign raw     = bus.cnt < duty_a;

  // Free-running period counter and wrap pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.cnt        <= '0;
      bus.period_end <= 1'b0;
    end else begin
      bus.period_end <= wrap_ev;
      if (bus.start)
        bus.cnt <= wrap ? '0 : bus.cnt + 1'b1;
    end
  end

  // Shadow capture; active set only changes on a wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      period_a <= P0;
      duty_a   <= D0;
      dt_a     <= T0;
      period_s <= P0;
      duty_s   <= D0;
      dt_s     <= T0;
      pending  <= 1'b0;
    end else if (wrap_ev) begin
      pending <= 1'b0;
      if (bus.load) begin
        period_a <= bus.period;
        duty_a   <= bus.duty;
        dt_a     <= bus.dead_time;
      end else if (pending) begin
        period_a <= period_s;
        duty_a   <= duty_s;
        dt_a     <= dt_s;
      end
    end else if (bus.load) begin
      period_s <= bus.period;
      duty_s   <= bus.duty;
      dt_s     <= bus.dead_time;
      pending  <= 1'b1;
    end
  end

  // Dead-time insertion around every raw PWM edge
  always_ff @(posedge clk) begin
    if (reset || !bus.start) begin
      bus.Fsw   <= 1'b0;
      bus.Fsw_n <= 1'b0;
      raw_q     <= 1'b0;
      dt_cnt    <= '0;
    end else if (raw != raw_q) begin
      raw_q <= raw;
      if (dt_a != '0) begin
        dt_cnt    <= dt_a - 1'b1;
        bus.Fsw   <= 1'b0;
        bus.Fsw_n <= 1'b0;
      end else begin
        bus.Fsw   <= raw;
        bus.Fsw_n <= ~raw;
      end
    end else if (dt_cnt != '0) begin
      dt_cnt    <= dt_cnt - 1'b1;
      bus.Fsw   <= 1'b0;
      bus.Fsw_n <= 1'b0;
    end else begin
      bus.Fsw   <= raw_q;
      bus.Fsw_n <= ~raw_q;
    end
  end
endmodule

// File: tb/tb_pwm_clock_source_dt.sv
// Randomised and directed bench for pwm_clock_source_dt
// against a per-cycle behavioural model.
module tb_pwm_clock_source_dt;
  localparam int W  = 7;
  localparam int DW = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_clock_source_dt_if #(.WIDTH(W), .DT_W(DW)) bus();

  pwm_clock_source_dt #(
    .WIDTH(W), .DT_W(DW),
    .DEF_PERIOD(100), .DEF_DUTY(20), .DEF_DT(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // model: counter, active/next config, edge-age tracker
  int m_cnt, m_per, m_duty, m_dt;
  int s_per, s_duty, s_dt;
  bit m_pend;
  int lvl, since, win;
  bit e_fsw, e_fswn, e_pe;

  function automatic logic [9:0] expv();
    return {7'(m_cnt), e_fsw, e_fswn, e_pe};
  endfunction

  function automatic logic [9:0] got();
    return {bus.cnt, bus.Fsw, bus.Fsw_n, bus.period_end};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_per = 100; m_duty = 20; m_dt = 0;
    s_per = 100; s_duty = 20; s_dt = 0; m_pend = 0;
    lvl = 0; since = 255; win = 0;
    e_fsw = 0; e_fswn = 0; e_pe = 0;
  endtask

  task automatic model_step();
    int raw, wrap;
    bit st, ld;
    st   = bus.start;
    ld   = bus.load;
    raw  = (m_cnt < m_duty) ? 1 : 0;
    wrap = (m_cnt >= m_per) ? 1 : 0;
    e_pe = st && wrap != 0;
    if (!st) begin
      lvl = 0; since = 255;
    end else if (raw != lvl) begin
      lvl = raw; since = 0; win = m_dt;
    end else if (since < 255) begin
      since++;
    end
    if (!st || since < win) begin
      e_fsw = 0; e_fswn = 0;
    end else begin
      e_fsw = (lvl != 0); e_fswn = (lvl == 0);
    end
    if (st && wrap != 0) begin
      if (ld) begin
        m_per = int'(bus.period); m_duty = int'(bus.duty);
        m_dt = int'(bus.dead_time);
      end else if (m_pend) begin
        m_per = s_per; m_duty = s_duty; m_dt = s_dt;
      end
      m_pend = 0;
    end else if (ld) begin
      s_per = int'(bus.period); s_duty = int'(bus.duty);
      s_dt = int'(bus.dead_time); m_pend = 1;
    end
    if (st) m_cnt = (wrap != 0) ? 0 : m_cnt + 1;
  endtask

  task automatic tick();
    if (reset) model_reset();
    else model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int p, input int d, input int t);
    bus.period = 7'(p); bus.duty = 7'(d);
    bus.dead_time = 4'(t); bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.load = 1'b0;
    bus.period = '0; bus.duty = '0; bus.dead_time = '0;
    tick(); tick();
    total++;
    if (got() !== 10'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", got(), 10'b0);
    end
    reset = 1'b0;
  endtask

  task automatic test_defaults();
    int hi = 0, lo = 0, pe = 0;
    bus.start = 1'b1;
    for (int i = 0; i < 202; i++) begin
      tick();
      total++;
      if (got() !== expv()) begin
        bad++;
        $display("FAIL defaults_cyc%0d got=%b want=%b", i, got(), expv());
      end
      if (i <= 100) begin
        hi += int'(bus.Fsw);
        lo += int'(bus.Fsw_n);
      end
      pe += int'(bus.period_end);
    end
    total += 3;
    if (hi != 20) begin
      bad++; $display("FAIL defaults_high got=%0d want=20", hi);
    end
    if (lo != 81) begin
      bad++; $display("FAIL defaults_low got=%0d want=81", lo);
    end
    if (pe != 2) begin
      bad++; $display("FAIL defaults_pe got=%0d want=2", pe);
    end
  endtask

  task automatic test_dead_time();
    int hi = 0, lo = 0, n = 0;
    do_load(100, 20, 3);
    while (!bus.period_end && n < 300) begin
      tick(); n++;
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL dt_wait got=%b want=%b", got(), expv());
      end
    end
    total++;
    if (n >= 300) begin
      bad++; $display("FAIL dt_timeout got=%0d want=<300", n);
    end
    for (int i = 0; i < 101; i++) begin
      tick();
      total++;
      if (got() !== expv() || (bus.Fsw && bus.Fsw_n)) begin
        bad++;
        $display("FAIL dt_cyc%0d got=%b want=%b", i, got(), expv());
      end
      hi += int'(bus.Fsw);
      lo += int'(bus.Fsw_n);
    end
    total += 2;
    if (hi != 17) begin
      bad++; $display("FAIL dt_high got=%0d want=17", hi);
    end
    if (lo != 78) begin
      bad++; $display("FAIL dt_low got=%0d want=78", lo);
    end
  endtask

  task automatic test_shadow();
    int n = 0, len = 0, hi = 0;
    while (bus.cnt != 7'd40 && n < 200) begin
      tick(); n++;
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL sh_wait got=%b want=%b", got(), expv());
      end
    end
    do_load(49, 25, 0);
    n = 0;
    while (!bus.period_end && n < 200) begin
      tick(); n++;
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL sh_cur got=%b want=%b", got(), expv());
      end
    end
    total++;
    if (n != 60) begin
      bad++; $display("FAIL sh_cur_len got=%0d want=60", n);
    end
    do begin
      tick(); len++;
      hi += int'(bus.Fsw);
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL sh_next got=%b want=%b", got(), expv());
      end
    end while (!bus.period_end && len < 200);
    total += 2;
    if (len != 50) begin
      bad++; $display("FAIL sh_next_len got=%0d want=50", len);
    end
    if (hi != 25) begin
      bad++; $display("FAIL sh_next_high got=%0d want=25", hi);
    end
  endtask

  task automatic test_duty_extremes();
    int hi, lo, n;
    do_load(100, 0, 0);
    n = 0;
    while (!bus.period_end && n < 300) begin
      tick(); n++;
    end
    hi = 0; lo = 0;
    for (int i = 0; i < 101; i++) begin
      tick();
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL d0_cyc got=%b want=%b", got(), expv());
      end
      hi += int'(bus.Fsw); lo += int'(bus.Fsw_n);
    end
    total++;
    if (hi != 0 || lo != 101) begin
      bad++; $display("FAIL duty0 got=%0d/%0d want=0/101", hi, lo);
    end
    do_load(9, 10, 0);
    n = 0;
    while (!bus.period_end && n < 300) begin
      tick(); n++;
    end
    hi = 0; lo = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL dfull_cyc got=%b want=%b", got(), expv());
      end
      hi += int'(bus.Fsw); lo += int'(bus.Fsw_n);
    end
    total++;
    if (hi != 20 || lo != 0) begin
      bad++; $display("FAIL dutyfull got=%0d/%0d want=20/0", hi, lo);
    end
  endtask

  task automatic test_pause();
    int n = 0;
    do_load(100, 20, 2);
    while (!bus.period_end && n < 300) begin
      tick(); n++;
    end
    n = 0;
    while (bus.cnt != 7'd10 && n < 200) begin
      tick(); n++;
    end
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (bus.cnt !== 7'd10 || bus.Fsw !== 1'b0 || bus.Fsw_n !== 1'b0) begin
        bad++;
        $display("FAIL pause got=%0d,%b%b want=10,00",
                 bus.cnt, bus.Fsw, bus.Fsw_n);
      end
    end
    bus.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL resume got=%b want=%b", got(), expv());
      end
    end
    total++;
    if ({bus.cnt, bus.Fsw, bus.Fsw_n} !== {7'd13, 2'b10}) begin
      bad++;
      $display("FAIL resume_dt got=%0d,%b%b want=13,10",
               bus.cnt, bus.Fsw, bus.Fsw_n);
    end
  endtask

  task automatic test_reset_pending();
    int n = 0, first = -1;
    while (bus.cnt != 7'd60 && n < 200) begin
      tick(); n++;
    end
    do_load(30, 5, 1);
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if (got() !== 10'b0) begin
      bad++; $display("FAIL rst_mid got=%b want=%b", got(), 10'b0);
    end
    reset = 1'b0;
    for (int i = 0; i < 150; i++) begin
      tick();
      total++;
      if (got() !== expv()) begin
        bad++; $display("FAIL rst_def got=%b want=%b", got(), expv());
      end
      if (bus.period_end && first < 0) first = i;
    end
    total++;
    if (first != 100) begin
      bad++; $display("FAIL rst_pe_at got=%0d want=100", first);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      bus.load = ($urandom_range(0, 29) == 0);
      bus.period = 7'($urandom_range(0, 127));
      bus.duty = 7'($urandom_range(0, 127));
      bus.dead_time = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 59) == 0) bus.start = ~bus.start;
      reset = ($urandom_range(0, 999) == 0);
      tick();
      total++;
      if (got() !== expv() || (bus.Fsw && bus.Fsw_n)) begin
        bad++;
        $display("FAIL rand_cyc%0d got=%b want=%b", i, got(), expv());
      end
    end
    reset = 1'b0; bus.load = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_defaults();
    test_dead_time();
    test_shadow();
    test_duty_extremes();
    test_pause();
    test_reset_pending();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
